vec_alu_seq: RTL and testbench
==============================

VEC_ALU_SEQ -- requirements
Module: vec_alu_seq

Interface
REQ-001 The block SHALL have parameter VLEN, default 128: vector register width in bits; legal values are powers of two, 64 to 1024.
REQ-002 The block SHALL have parameter XLEN, default 64: scalar operand width in bits.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid  input  1  request presented.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-007 The block SHALL have port op  input  4  operation code.
REQ-008 The block SHALL have port sew  input  3  element width code: 0=8, 1=16, 2=32, 3=64 bits.
REQ-009 The block SHALL have ports vs1 and vs2  input  VLEN  vector operands.
REQ-010 The block SHALL have port scalar  input  XLEN  scalar operand; its low SEW bits are used.
REQ-011 The block SHALL have port out_valid  output  1  result valid.
REQ-012 The block SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 The block SHALL have port result  output  VLEN  result vector.
REQ-014 The block SHALL have port err  output  1  illegal request flag; qualified by out_valid.

Function
REQ-015 Acceptance SHALL occur on a rising edge where in_valid and in_ready are both 1; op, sew, vs1, vs2 and scalar SHALL be captured internally at that edge; later input changes have no effect.
REQ-016 in_ready SHALL equal (state==IDLE) and (out_valid==0 or out_ready==1).
REQ-017 Ops SHALL be: 0 vs1+vs2, 1 vs1+scalar, 2 vs1-vs2, 3 vs1-scalar, 4 vs1*vs2, 5 vs1*scalar, 6 signed min reduction of vs1, 7 signed max reduction of vs1, 8 sum reduction of vs1.
REQ-018 Element arithmetic SHALL be per SEW lane, wrap modulo 2^SEW, with no carry between lanes; multiply SHALL return the low SEW bits of the signed product.
REQ-019 Elementwise ops (0-5) SHALL assert out_valid on the edge after acceptance.
REQ-020 Reductions (6-8) SHALL use an FSM IDLE -> REDUCE -> IDLE: at acceptance the accumulator loads element 0 and idx=1; each REDUCE cycle combines element idx and then increments idx; the cycle that combines element N-1 (N=VLEN/SEW) writes the result, sets out_valid and returns to IDLE.
REQ-021 Reduction latency SHALL be N-1 cycles from acceptance to out_valid (e.g. VLEN=128: SEW8 = 15 cycles, SEW64 = 1 cycle).
REQ-022 The reduction result SHALL occupy element 0 of result, with all higher bits 0; the sum SHALL wrap modulo 2^SEW.
REQ-023 The result, err and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 out_valid SHALL clear on an edge with out_ready=1 unless a new request is accepted on the same edge, in which case back-to-back elementwise ops SHALL sustain one result per cycle.
REQ-025 An op code of 9-15 or an sew code of 4-7 SHALL be accepted, complete after 1 cycle with result=0 and err=1, and otherwise err=0.
REQ-026 in_valid while in_ready=0 SHALL be ignored, with no capture and no state change.

Reset
REQ-027 Assertion of rst_n=0 SHALL immediately, without a clock, force state=IDLE, out_valid=0, result=0, err=0, accumulator=0 and idx=0.
REQ-028 A reset during REDUCE SHALL abort the reduction, and no result for it SHALL ever be produced.
REQ-029 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 on the first clock edge after deassertion.

Verification
REQ-030 VLEN=128, op0, sew0, vs1 all bytes 0xFF, vs2 all bytes 0x02 -> one cycle later out_valid=1, result all bytes 0x01, err=0.
REQ-031 op5, sew1, vs1 lanes 0x0003, scalar=0xFFFF (-1) -> result all lanes 0xFFFD; a second op0 request on the next cycle with out_ready=1 -> results on consecutive cycles.
REQ-032 op6, sew0, vs1 bytes 0..15 = 5,0x80,7,...,0x7F -> in_ready=0 for 15 cycles, then result=0x...0080 (only byte 0 nonzero), out_valid=1.
REQ-033 op8, sew3, vs1={0xFFFF_FFFF_FFFF_FFFF, 0x2} -> after 1 cycle, result[63:0]=0x1 and result[127:64]=0.
REQ-034 Start op7 with sew0, pull rst_n low at cycle 5 -> out_valid=0 immediately; after release the next request completes normally and no stale result appears.
REQ-035 Hold out_ready=0 for 10 cycles after a result -> result stable and in_ready=0 throughout; op=12 -> err=1 and result=0.

Source files
------------

// File: rtl/vec_alu_seq_if.sv
// Request/response bundle for vec_alu_seq: one request handshake in, one result handshake out.
interface vec_alu_seq_if #(
    parameter int VLEN = 128,
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [2:0]      sew;
    logic [VLEN-1:0] vs1;
    logic [VLEN-1:0] vs2;
    logic [XLEN-1:0] scalar;
    logic            out_valid;
    logic            out_ready;
    logic [VLEN-1:0] result;
    logic            err;

    modport master (
        output in_valid, op, sew, vs1, vs2, scalar, out_ready,
        input  in_ready, out_valid, result, err
    );

    modport slave (
        input  in_valid, op, sew, vs1, vs2, scalar, out_ready,
        output in_ready, out_valid, result, err
    );
endinterface

// File: rtl/vec_alu_seq.sv
// Vector ALU: single-cycle elementwise add/sub/mul per SEW lane, multi-cycle
// min/max/sum reductions walked one element per cycle, single output register.
module vec_alu_seq_lane #(
    parameter int W = 8
) (
    input  logic [1:0]   fn_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] r_o
);
    // Low W bits of a product are identical for signed and unsigned operands.
    always_comb begin
        case (fn_i)
            2'd0:    r_o = a_i + b_i;
            2'd1:    r_o = a_i - b_i;
            default: r_o = a_i * b_i;
        endcase
    end
endmodule

module vec_alu_seq #(
    parameter int VLEN = 128,
    parameter int XLEN = 64
) (
    input logic          clk,
    input logic          rst_n,
    vec_alu_seq_if.slave vif
);
    localparam int NB   = VLEN / 8;
    localparam int IDXW = $clog2(NB) + 1;

    typedef enum logic {IDLE, REDUCE} state_t;

    state_t            state_q, state_d;
    logic              ov_q, ov_d;
    logic [VLEN-1:0]   res_q, res_d;
    logic              err_q, err_d;
    logic [63:0]       acc_q, acc_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        sew_q, sew_d;
    logic [VLEN-1:0]   vs1_q, vs1_d;
    logic              rdy_q;

    logic              in_ready_w;
    logic              accept;
    logic [63:0]       e0, en, acc_n;
    logic [63:0]       scal64;
    logic [1:0]        fn;
    logic [3:0][VLEN-1:0] ew_res;

    function automatic logic [IDXW-1:0] last_idx(input logic [1:0] s);
        return IDXW'((NB >> s) - 1);
    endfunction

    function automatic logic [63:0] sew_mask(input logic [1:0] s);
        logic [63:0] m;
        case (s)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // Element i of v, sign-extended to 64 bits so one comparator serves all widths.
    function automatic logic [63:0] elem(input logic [VLEN-1:0] v, input logic [1:0] s,
                                         input logic [IDXW-1:0] i);
        logic [VLEN-1:0] t;
        logic [63:0]     e;
        t = v >> (32'(i) << (32'd3 + 32'(s)));
        case (s)
            2'd0:    e = {{56{t[7]}},  t[7:0]};
            2'd1:    e = {{48{t[15]}}, t[15:0]};
            2'd2:    e = {{32{t[31]}}, t[31:0]};
            default: e = t[63:0];
        endcase
        return e;
    endfunction

    function automatic logic [63:0] combine(input logic [3:0] o, input logic [63:0] a,
                                            input logic [63:0] e);
        logic [63:0] r;
        case (o)
            4'd6:    r = ($signed(e) < $signed(a)) ? e : a;
            4'd7:    r = ($signed(e) > $signed(a)) ? e : a;
            default: r = a + e;
        endcase
        return r;
    endfunction

    assign scal64 = 64'(vif.scalar);
    assign fn     = vif.op[2:1];

    // Every SEW has its own lane array; the output mux picks one by sew.
    for (genvar g = 0; g < 4; g++) begin : g_sew
        localparam int W = 8 << g;
        for (genvar l = 0; l < VLEN / W; l++) begin : g_lane
            vec_alu_seq_lane #(.W(W)) u_lane (
                .fn_i (fn),
                .a_i  (vif.vs1[l*W +: W]),
                .b_i  (vif.op[0] ? scal64[W-1:0] : vif.vs2[l*W +: W]),
                .r_o  (ew_res[g][l*W +: W])
            );
        end
    end

    assign in_ready_w    = rdy_q && (state_q == IDLE) && (!ov_q || vif.out_ready);
    assign accept        = vif.in_valid && in_ready_w;
    assign vif.in_ready  = in_ready_w;
    assign vif.out_valid = ov_q;
    assign vif.result    = res_q;
    assign vif.err       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ov_q    <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
            acc_q   <= '0;
            idx_q   <= '0;
            op_q    <= '0;
            sew_q   <= '0;
            vs1_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ov_q    <= ov_d;
            res_q   <= res_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            sew_q   <= sew_d;
            vs1_q   <= vs1_d;
            rdy_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ov_d    = ov_q;
        res_d   = res_q;
        err_d   = err_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        op_d    = op_q;
        sew_d   = sew_q;
        vs1_d   = vs1_q;
        e0      = '0;
        en      = '0;
        acc_n   = acc_q;
        case (state_q)
            IDLE: begin
                if (ov_q && vif.out_ready) ov_d = 1'b0;
                if (accept) begin
                    op_d  = vif.op;
                    sew_d = vif.sew[1:0];
                    vs1_d = vif.vs1;
                    if (vif.op > 4'd8 || vif.sew > 3'd3) begin
                        res_d = '0;
                        err_d = 1'b1;
                        ov_d  = 1'b1;
                    end else if (vif.op < 4'd6) begin
                        res_d = ew_res[vif.sew[1:0]];
                        err_d = 1'b0;
                        ov_d  = 1'b1;
                    end else begin
                        e0 = elem(vif.vs1, vif.sew[1:0], '0);
                        // A single-element vector has nothing left to combine.
                        if (last_idx(vif.sew[1:0]) == '0) begin
                            res_d = VLEN'(e0 & sew_mask(vif.sew[1:0]));
                            err_d = 1'b0;
                            ov_d  = 1'b1;
                        end else begin
                            acc_d   = e0;
                            idx_d   = IDXW'(1);
                            state_d = REDUCE;
                        end
                    end
                end
            end
            REDUCE: begin
                en    = elem(vs1_q, sew_q, idx_q);
                acc_n = combine(op_q, acc_q, en);
                acc_d = acc_n;
                idx_d = idx_q + 1'b1;
                if (idx_q == last_idx(sew_q)) begin
                    res_d   = VLEN'(acc_n & sew_mask(sew_q));
                    err_d   = 1'b0;
                    ov_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_vec_alu_seq.sv
// Directed bench for vec_alu_seq with a reference model feeding an expected-result queue.
module tb_vec_alu_seq;
    typedef struct packed {
        logic [127:0] res;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc_n = 0;
    int   last_pop = 0;
    int   prev_pop = 0;
    logic rdy_neg;
    logic acc_flag;
    exp_t exp_next;
    exp_t sb[$];

    vec_alu_seq_if #(.VLEN(128), .XLEN(64)) vif ();

    vec_alu_seq #(.VLEN(128), .XLEN(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (vif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] m_ew(input logic [3:0] o, input logic [1:0] s,
                                          input logic [127:0] a, input logic [127:0] b,
                                          input logic [63:0] sc);
        int w;
        logic [63:0] m, x, y, z;
        logic [127:0] r;
        w = 8 << s;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        r = '0;
        for (int l = 0; l < 128 / w; l++) begin
            x = 64'(a >> (l * w)) & m;
            y = o[0] ? (sc & m) : (64'(b >> (l * w)) & m);
            case (o[2:1])
                2'd0:    z = x + y;
                2'd1:    z = x - y;
                default: z = x * y;
            endcase
            r = r | (128'(z & m) << (l * w));
        end
        return r;
    endfunction

    function automatic logic [127:0] m_red(input logic [3:0] o, input logic [1:0] s,
                                           input logic [127:0] a);
        int w;
        logic [63:0] m, t;
        longint acc, e;
        w = 8 << s;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        acc = 0;
        for (int l = 0; l < 128 / w; l++) begin
            t = 64'(a >> (l * w)) << (64 - w);
            e = $signed(t) >>> (64 - w);
            if (l == 0) acc = e;
            else if (o == 4'd6) acc = (e < acc) ? e : acc;
            else if (o == 4'd7) acc = (e > acc) ? e : acc;
            else acc = acc + e;
        end
        return 128'(64'(acc) & m);
    endfunction

    function automatic exp_t model(input logic [3:0] o, input logic [2:0] s,
                                   input logic [127:0] a, input logic [127:0] b,
                                   input logic [63:0] sc);
        exp_t r;
        if (o > 4'd8 || s > 3'd3) begin
            r.res = '0;
            r.err = 1'b1;
        end else if (o < 4'd6) begin
            r.res = m_ew(o, s[1:0], a, b, sc);
            r.err = 1'b0;
        end else begin
            r.res = m_red(o, s[1:0], a);
            r.err = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One clock: sample at negedge (scoreboard pop, acceptance), then step past posedge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        rdy_neg = vif.in_ready;
        if (vif.out_valid && vif.out_ready) begin
            chk("sb_pending", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_result", vif.result, e.res);
                chk("sb_err", 128'(vif.err), 128'(e.err));
                prev_pop = last_pop;
                last_pop = cyc_n;
            end
        end
        if (vif.in_valid && vif.in_ready) begin
            sb.push_back(exp_next);
            acc_flag = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic send(input logic [3:0] o, input logic [2:0] s, input logic [127:0] a,
                        input logic [127:0] b, input logic [63:0] sc);
        vif.op       = o;
        vif.sew      = s;
        vif.vs1      = a;
        vif.vs2      = b;
        vif.scalar   = sc;
        vif.in_valid = 1'b1;
        exp_next     = model(o, s, a, b, sc);
        acc_flag     = 1'b0;
        for (int i = 0; i < 40 && !acc_flag; i++) cyc();
        chk("accept", 128'(acc_flag), 128'(1));
        vif.in_valid = 1'b0;
    endtask

    initial begin
        logic [127:0] v;
        logic [127:0] held;
        int n;
        vif.in_valid  = 1'b0;
        vif.out_ready = 1'b1;
        vif.op        = '0;
        vif.sew       = '0;
        vif.vs1       = '0;
        vif.vs2       = '0;
        vif.scalar    = '0;

        // Reset state and release timing
        #23;
        chk("rst_out_valid", 128'(vif.out_valid), 128'(0));
        chk("rst_in_ready", 128'(vif.in_ready), 128'(0));
        chk("rst_result", vif.result, 128'(0));
        chk("rst_err", 128'(vif.err), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rel_in_ready_pre", 128'(vif.in_ready), 128'(0));
        cyc();
        chk("rel_in_ready_post", 128'(vif.in_ready), 128'(1));

        // Byte add wrap: 0xFF + 0x02 = 0x01 per lane
        send(4'd0, 3'd0, {16{8'hFF}}, {16{8'h02}}, 64'd0);
        chk("ew_ov_lat", 128'(vif.out_valid), 128'(1));
        chk("ew_wrap_res", vif.result, {16{8'h01}});
        cyc();

        // Halfword multiply by scalar -1 then back-to-back add
        send(4'd5, 3'd1, {8{16'h0003}}, '0, 64'h0000_0000_0000_FFFF);
        chk("mul_neg_res", vif.result, {8{16'hFFFD}});
        send(4'd0, 3'd1, {8{16'h1234}}, {8{16'h0101}}, 64'd0);
        cyc();
        chk("b2b_spacing", 128'(last_pop - prev_pop), 128'(1));

        // Signed byte min over 16 elements
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(i * 3 + 1);
        v[7:0] = 8'h05; v[15:8] = 8'h80; v[23:16] = 8'h07; v[127:120] = 8'h7F;
        send(4'd6, 3'd0, v, '0, 64'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (rdy_neg) break;
            n++;
        end
        chk("min8_busy_cycles", 128'(n), 128'(15));

        // Sum of {-1, 2} at SEW64: one cycle
        send(4'd8, 3'd3, {64'h0000_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF}, '0, 64'd0);
        chk("sum64_busy", 128'(vif.out_valid), 128'(0));
        cyc();
        chk("sum64_ov", 128'(vif.out_valid), 128'(1));
        chk("sum64_res", vif.result, 128'h1);
        cyc();

        // Further reductions and elementwise ops with random data
        send(4'd7, 3'd1, {$urandom, $urandom, $urandom, $urandom}, '0, 64'd0);
        send(4'd8, 3'd2, {$urandom, $urandom, $urandom, $urandom}, '0, 64'd0);
        send(4'd6, 3'd3, {$urandom, $urandom, $urandom, $urandom}, '0, 64'd0);
        for (int i = 0; i < 8; i++)
            send(4'($urandom_range(0, 5)), 3'($urandom_range(0, 3)),
                 {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();

        // Reset during a max reduction: aborted result must never appear
        send(4'd7, 3'd0, {$urandom, $urandom, $urandom, $urandom}, '0, 64'd0);
        for (int i = 0; i < 4; i++) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ov", 128'(vif.out_valid), 128'(0));
        chk("abort_in_ready", 128'(vif.in_ready), 128'(0));
        chk("abort_result", vif.result, 128'(0));
        void'(sb.pop_back());
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_rel_pre", 128'(vif.in_ready), 128'(0));
        cyc();
        chk("abort_rel_post", 128'(vif.in_ready), 128'(1));
        send(4'd2, 3'd2, {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 64'd0);
        for (int i = 0; i < 20; i++) cyc();

        // Backpressure: result held, ignored request while stalled
        vif.out_ready = 1'b0;
        send(4'd1, 3'd2, {$urandom, $urandom, $urandom, $urandom}, '0, {$urandom, $urandom});
        held = sb[0].res;
        vif.op = 4'd0; vif.sew = 3'd0; vif.vs1 = '1; vif.vs2 = '1;
        vif.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("hold_result", vif.result, held);
            chk("hold_ov", 128'(vif.out_valid), 128'(1));
            chk("hold_in_ready", 128'(rdy_neg), 128'(0));
        end
        vif.in_valid = 1'b0;
        vif.out_ready = 1'b1;
        cyc();

        // Illegal op and illegal sew
        send(4'd12, 3'd0, '1, '1, '1);
        chk("illegal_op_err", 128'(vif.err), 128'(1));
        chk("illegal_op_res", vif.result, 128'(0));
        send(4'd0, 3'd5, '1, '1, '1);
        chk("illegal_sew_err", 128'(vif.err), 128'(1));
        for (int i = 0; i < 3; i++) cyc();

        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
